// File: rtl/instr_prefetch_queue.sv
// instr_prefetch_queue: sequential instruction fetch with credit-limited FIFO and redirect flush.
// Optional perf counters are built when PF_PERF_CNT_EN is defined.
module instr_prefetch_queue #(
    parameter int          DEPTH   = 4,
    parameter logic [63:0] PC_STEP = 64'd4
) (
    input  logic        CLK,
    input  logic        resetl,
    input  logic [63:0] startpc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] fetch_count,
    output logic [31:0] flush_count
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      r_state, w_next;
    logic [63:0] r_fetch_pc, r_req_pc;
    logic [31:0] r_mem_data [DEPTH];
    logic [63:0] r_mem_pc [DEPTH];
    logic [AW-1:0] r_rd, r_wr, w_rd_n;
    logic [AW:0]   r_cnt, w_cnt_n;
    logic        r_inst_valid;
    logic [31:0] r_inst_data, w_head_data;
    logic [63:0] r_inst_pc, w_head_pc;
    logic        w_push, w_pop, w_out, w_credit, w_accept, w_fwd;

    assign w_out    = r_state == WAIT || r_state == DROP;
    assign w_credit = (int'(r_cnt) + int'(w_out)) < DEPTH;
    assign w_accept = r_state == REQ && mem_req_ready;
    assign w_push   = r_state == WAIT && mem_rsp_valid && !redirect_valid;
    assign w_pop    = r_inst_valid && inst_ready && !redirect_valid;
    assign w_cnt_n  = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_rd_n   = r_rd + AW'(w_pop);
    // A push into an otherwise-empty queue bypasses the array so the head is ready next cycle.
    assign w_fwd       = w_push && w_cnt_n == (AW+1)'(1);
    assign w_head_data = w_fwd ? mem_rsp_data : r_mem_data[w_rd_n];
    assign w_head_pc   = w_fwd ? r_req_pc : r_mem_pc[w_rd_n];

    always_ff @(posedge CLK) begin
        if (resetl)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // A stale request still in flight after a redirect must be drained in DROP.
    always_comb begin
        w_next = r_state;
        if (redirect_valid)
            w_next = ((w_out && !mem_rsp_valid) || w_accept) ? DROP : REQ;
        else
            w_next = r_state == IDLE ? (w_credit ? REQ : IDLE)
                   : r_state == REQ  ? (mem_req_ready ? WAIT : REQ)
                   : r_state == WAIT ? (mem_rsp_valid ? ((int'(w_cnt_n) < DEPTH) ? REQ : IDLE) : WAIT)
                   : (mem_rsp_valid ? REQ : DROP);
    end

    always_comb begin
        mem_req_valid = r_state == REQ;
        mem_req_addr  = r_fetch_pc;
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_fetch_pc   <= startpc;
            r_req_pc     <= '0;
            r_rd         <= '0;
            r_wr         <= '0;
            r_cnt        <= '0;
            r_inst_valid <= 1'b0;
            r_inst_data  <= '0;
            r_inst_pc    <= '0;
        end else begin
            if (w_accept)
                r_req_pc <= r_fetch_pc;
            if (redirect_valid)
                r_fetch_pc <= redirect_pc;
            else if (w_accept)
                r_fetch_pc <= r_fetch_pc + PC_STEP;
            if (redirect_valid) begin
                r_rd         <= '0;
                r_wr         <= '0;
                r_cnt        <= '0;
                r_inst_valid <= 1'b0;
            end else begin
                r_rd         <= w_rd_n;
                r_cnt        <= w_cnt_n;
                r_inst_valid <= w_cnt_n != '0;
                if (w_push)
                    r_wr <= r_wr + AW'(1);
                if (w_cnt_n != '0) begin
                    r_inst_data <= w_head_data;
                    r_inst_pc   <= w_head_pc;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_data[r_wr] <= mem_rsp_data;
            r_mem_pc[r_wr]   <= r_req_pc;
        end
    end

    assign inst_valid = r_inst_valid;
    assign inst_data  = r_inst_data;
    assign inst_pc    = r_inst_pc;

`ifdef PF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt, r_flush_cnt;

    always_ff @(posedge CLK) begin
        if (resetl) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (mem_req_valid && mem_req_ready)
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            if (redirect_valid)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign fetch_count = r_fetch_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb_instr_prefetch_queue: cycle-by-cycle directed vectors for the prefetch queue.
module tb_instr_prefetch_queue;
    logic        CLK = 1'b0;
    logic        resetl = 1'b1;
    logic [63:0] startpc = 64'h1000;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready = 1'b1;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready = 1'b1;
    logic [31:0] fetch_count, flush_count;

    int passed = 0;
    int total  = 0;

    instr_prefetch_queue dut (
        .CLK(CLK), .resetl(resetl), .startpc(startpc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc), .inst_ready(inst_ready),
        .fetch_count(fetch_count), .flush_count(flush_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, rdv;
        logic [63:0] rpc;
        logic        rdy, rv;
        logic [31:0] rd;
        logic        irdy, ck, ev;
        logic [63:0] ea;
        logic        iv;
        logic [31:0] id;
        logic [63:0] ip;
    } vec_t;

    vec_t vec[$];

    task automatic add(input logic rst, input logic rdv, input logic [63:0] rpc, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic irdy, input logic ck,
                       input logic ev, input logic [63:0] ea, input logic iv, input logic [31:0] id,
                       input logic [63:0] ip);
        vec_t v;
        v.rst = rst; v.rdv = rdv; v.rpc = rpc; v.rdy = rdy; v.rv = rv; v.rd = rd; v.irdy = irdy;
        v.ck = ck; v.ev = ev; v.ea = ea; v.iv = iv; v.id = id; v.ip = ip;
        vec.push_back(v);
    endtask

    task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", n, act, exp);
    endtask

    localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef PF_PERF_CNT_EN
    localparam logic [31:0] EXP_FETCH = 32'd15, EXP_FLUSH = 32'd5;
`else
    localparam logic [31:0] EXP_FETCH = 32'd0, EXP_FLUSH = 32'd0;
`endif

    initial begin
        //   rst rdv rpc        rdy rv data   irdy | ck ev addr     iv data  pc
        add(1, 0, 0,          1, 0, 0,     1,  0, 0, 0,       0, 0,    0);
        add(0, 0, 0,          1, 0, 0,     1,  1, 0, 0,       0, 0,    0);
        add(0, 0, 0,          1, 0, 0,     1,  1, 1, 'h1000,  0, 0,    0);
        add(0, 0, 0,          1, 1, 'hA0,  1,  1, 0, 0,       0, 0,    0);
        add(0, 0, 0,          1, 0, 0,     1,  1, 1, 'h1004,  1, 'hA0, 'h1000);
        add(0, 0, 0,          1, 1, 'hA1,  1,  1, 0, 0,       0, 'hA0, 'h1000);
        add(0, 0, 0,          1, 0, 0,     1,  1, 1, 'h1008,  1, 'hA1, 'h1004);
        add(0, 0, 0,          1, 1, 'hA2,  1,  1, 0, 0,       0, 'hA1, 'h1004);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h100C,  1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 1, 'hA3,  0,  1, 0, 0,       1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h1010,  1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 1, 'hA4,  0,  1, 0, 0,       1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h1014,  1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 1, 'hA5,  0,  1, 0, 0,       1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 0, 0,     0,  1, 0, 0,       1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 0, 0,     1,  1, 0, 0,       1, 'hA2, 'h1008);
        add(0, 0, 0,          1, 0, 0,     0,  1, 0, 0,       1, 'hA3, 'h100C);
        add(0, 0, 0,          0, 0, 0,     0,  1, 1, 'h1018,  1, 'hA3, 'h100C);
        add(0, 0, 0,          0, 0, 0,     0,  1, 1, 'h1018,  1, 'hA3, 'h100C);
        add(0, 0, 0,          0, 0, 0,     0,  1, 1, 'h1018,  1, 'hA3, 'h100C);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h1018,  1, 'hA3, 'h100C);
        add(0, 0, 0,          1, 1, 'hA6,  0,  1, 0, 0,       1, 'hA3, 'h100C);
        add(0, 1, 'h2000,     1, 0, 0,     1,  1, 0, 0,       1, 'hA3, 'h100C);
        add(0, 0, 0,          1, 0, 0,     1,  1, 1, 'h2000,  0, 'hA3, 'h100C);
        add(0, 0, 0,          1, 1, 'hB0,  1,  1, 0, 0,       0, 'hA3, 'h100C);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h2004,  1, 'hB0, 'h2000);
        add(0, 1, 'h3000,     1, 0, 0,     0,  1, 0, 0,       1, 'hB0, 'h2000);
        add(0, 0, 0,          1, 0, 0,     0,  1, 0, 0,       0, 'hB0, 'h2000);
        add(0, 0, 0,          1, 1, 'hDEAD,0,  1, 0, 0,       0, 'hB0, 'h2000);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h3000,  0, 'hB0, 'h2000);
        add(0, 0, 0,          1, 1, 'hC0,  0,  1, 0, 0,       0, 'hB0, 'h2000);
        add(0, 1, TOP,        1, 0, 0,     0,  1, 1, 'h3004,  1, 'hC0, 'h3000);
        add(0, 0, 0,          1, 1, 'hBAD, 0,  1, 0, 0,       0, 'hC0, 'h3000);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, TOP,     0, 'hC0, 'h3000);
        add(0, 0, 0,          1, 1, 'hD0,  0,  1, 0, 0,       0, 'hC0, 'h3000);
        add(0, 0, 0,          1, 0, 0,     1,  1, 1, 0,       1, 'hD0, TOP);
        add(0, 1, 'h4000,     1, 1, 'hBAD, 0,  1, 0, 0,       0, 'hD0, TOP);
        add(0, 1, 'h5000,     0, 0, 0,     0,  1, 1, 'h4000,  0, 'hD0, TOP);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h5000,  0, 'hD0, TOP);
        add(0, 0, 0,          1, 1, 'hE0,  0,  1, 0, 0,       0, 'hD0, TOP);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h5004,  1, 'hE0, 'h5000);
        add(0, 0, 0,          1, 1, 'hE1,  1,  1, 0, 0,       1, 'hE0, 'h5000);
        add(0, 0, 0,          1, 0, 0,     0,  1, 1, 'h5008,  1, 'hE1, 'h5004);

        for (int i = 0; i < vec.size(); i++) begin
            @(negedge CLK);
            resetl = vec[i].rst; redirect_valid = vec[i].rdv; redirect_pc = vec[i].rpc;
            mem_req_ready = vec[i].rdy; mem_rsp_valid = vec[i].rv; mem_rsp_data = vec[i].rd;
            inst_ready = vec[i].irdy;
            #1;
            if (vec[i].ck) begin
                check($sformatf("row%0d req_valid", i), 64'(mem_req_valid), 64'(vec[i].ev));
                if (vec[i].ev)
                    check($sformatf("row%0d req_addr", i), mem_req_addr, vec[i].ea);
                check($sformatf("row%0d inst_valid", i), 64'(inst_valid), 64'(vec[i].iv));
                check($sformatf("row%0d inst_data", i), 64'(inst_data), 64'(vec[i].id));
                check($sformatf("row%0d inst_pc", i), inst_pc, vec[i].ip);
            end
        end
        check("fetch_count", 64'(fetch_count), 64'(EXP_FETCH));
        check("flush_count", 64'(flush_count), 64'(EXP_FLUSH));

        // Reset while a request is outstanding, then restart from a new start address.
        @(negedge CLK);
        resetl = 1'b1; startpc = 64'h7000; mem_rsp_valid = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
        @(negedge CLK);
        resetl = 1'b0;
        #1;
        check("rst req_valid", 64'(mem_req_valid), 64'd0);
        check("rst inst_valid", 64'(inst_valid), 64'd0);
        check("rst inst_data", 64'(inst_data), 64'd0);
        check("rst inst_pc", inst_pc, 64'd0);
        check("rst fetch_count", 64'(fetch_count), 64'd0);
        check("rst flush_count", 64'(flush_count), 64'd0);
        @(negedge CLK);
        #1;
        check("restart req_valid", 64'(mem_req_valid), 64'd1);
        check("restart req_addr", mem_req_addr, 64'h7000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch stage directly upstream of the single-cycle datapath's instruction decode.
- Generates sequential 64-bit fetch addresses and issues requests to a variable-latency instruction memory over a valid/ready request and valid response interface.
- Buffers returned 32-bit instructions with their PCs in a FIFO and presents them to decode over a valid/ready handshake.
- Flushes all fetched instructions and restarts fetch on a branch redirect.

Parameters:
- DEPTH, 4, number of FIFO entries (power of 2, at least 2).
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- resetl  input  1  reset, synchronous, active-high.
- startpc  input  64  fetch address loaded at reset.
- redirect_valid  input  1  taken branch/jump; flush the FIFO and restart fetch.
- redirect_pc  input  64  new fetch address, sampled when redirect_valid=1.
- mem_req_valid  output  1  fetch request valid.
- mem_req_addr  output  64  fetch address.
- mem_req_ready  input  1  memory accepts the request this cycle.
- mem_rsp_valid  input  1  instruction word returned.
- mem_rsp_data  input  32  instruction word.
- inst_valid  output  1  FIFO head valid.
- inst_data  output  32  FIFO head instruction.
- inst_pc  output  64  FIFO head PC.
- inst_ready  input  1  decode consumes the head this cycle.
- fetch_count  output  32  perf counter (see Optional Feature).
- flush_count  output  32  perf counter (see Optional Feature).

Behaviour:
- Reset (resetl=1 at posedge):
  - FIFO empty; state IDLE; fetch_pc=startpc.
  - mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=0, counters=0.
  - Reset mid-transaction abandons any outstanding request.
  - The memory drops any in-flight response after reset.
- Exactly one outstanding memory request at a time.
- Credit rule: a request may be issued only when occupancy + outstanding < DEPTH.
- State IDLE:
  - If credit is available and there is no redirect, go to REQ.
- State REQ:
  - mem_req_valid=1, mem_req_addr=fetch_pc.
  - Address and valid stay stable until mem_req_ready=1.
  - On accept: req_pc<=fetch_pc, fetch_pc<=fetch_pc+PC_STEP (mod 2^64), go to WAIT.
- State WAIT:
  - On mem_rsp_valid: push {mem_rsp_data, req_pc} into the FIFO.
  - Then go to REQ if credit remains, else IDLE.
  - A response in the same cycle as the accept is not legal; the minimum memory latency is 1 cycle.
- State DROP:
  - Waits for the response to a request made stale by a redirect.
  - On mem_rsp_valid: discard the word and go to REQ.
- Redirect (redirect_valid=1), highest priority after reset:
  - FIFO cleared the same cycle; inst_valid=0 next cycle.
  - fetch_pc<=redirect_pc.
  - Next state: DROP if in WAIT, or in REQ with mem_req_ready=1 this cycle. Otherwise REQ.
  - A concurrent pop is ignored.
  - A concurrent mem_rsp_valid in WAIT is discarded, and the next state is REQ.
- FIFO:
  - Pop when inst_valid & inst_ready. Push and pop may occur in the same cycle; occupancy is then unchanged.
  - Push when full cannot occur, by the credit rule.
  - inst_data and inst_pc are registered from the head entry.
  - Latency from response to inst_valid is 1 cycle when the FIFO is empty.
- Outputs are held while inst_valid=1 and inst_ready=0.
- redirect_pc is not checked for alignment; it is used as given.

Optional Feature:
- Macro PF_PERF_CNT_EN.
- Defined:
  - fetch_count increments on each accepted request (mem_req_valid & mem_req_ready).
  - flush_count increments on each cycle redirect_valid=1.
  - Both counters wrap at 2^32 and clear on reset.
- Undefined: both outputs tied to 0 and no counter logic is synthesized.

Test Plan:
- Reset with startpc=0x1000, mem_req_ready=1, responses at 1-cycle latency -> requests to 0x1000, 0x1004, 0x1008; inst_pc matches in order; inst_valid rises 1 cycle after the first response.
- Hold inst_ready=0 with DEPTH=4 -> exactly 4 requests issued, then mem_req_valid stays 0. Release inst_ready -> one new request per pop.
- mem_req_ready=0 for 3 cycles in REQ -> mem_req_addr stable at 0x1008 and mem_req_valid held at 1 throughout.
- Redirect to 0x2000 while in WAIT for 0x1004 -> FIFO empty next cycle; the late 0x1004 response is discarded; the next request is 0x2000 and the first inst_pc is 0x2000.
- fetch_pc=0xFFFFFFFFFFFFFFFC -> the next request address is 0x0000000000000000.
- With PF_PERF_CNT_EN: 5 accepted requests and 2 redirects -> fetch_count=5, flush_count=2. Without the macro -> both outputs read 0.
